seq_detect_param: RTL and testbench

//  Run-time programmable serial pattern detector. It succeeds the fixed 10010 Mealy detector.

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_match_cnt.sv | 30 +++
 rtl/seq_detect_param.sv | 85 ++++++++
 tb/tb_seq_detect_param.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared defaults and helpers for the programmable sequence detector
package seq_det_pkg;

  localparam int              PKG_PAT_W = 5;
  localparam logic [4:0]      DEF_PAT   = 5'b10010;
  localparam int              DEF_LEN   = 5;

  // Low 'len' bits set; wide enough for any practical pattern width.
  function automatic logic [31:0] len_mask(input int len);
    if (len >= 32) return '1;
    return (32'd1 << len) - 32'd1;
  endfunction

  // A pattern length is usable only if it is 1..max_len.
  function automatic logic len_ok(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// rtl/seq_match_cnt.sv - saturating match counter with clear and sticky saturation flag
module seq_match_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  // Clear beats increment; an increment arriving at all-ones is lost and flags saturation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc) begin
      if (cnt == '1) begin
        sat <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - run-time programmable serial pattern detector with match counter
module seq_detect_param #(
  parameter int               PAT_W   = seq_det_pkg::PKG_PAT_W,
  parameter int               LEN_W   = 3,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = seq_det_pkg::DEF_PAT,
  parameter int               DEF_LEN = seq_det_pkg::DEF_LEN
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             data_vld,
  input  logic             data,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_val,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             match,
  output logic             match_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             cfg_err
);
  import seq_det_pkg::*;

  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;
  logic [PAT_W-1:0] hist_nx;
  logic [PAT_W-1:0] mask;
  logic             fill_ok;
  logic             load_ok;

  // Comparator: the incoming bit completes the pattern only once enough fresh bits are held.
  always_comb begin
    hist_nx = {hist[PAT_W-2:0], data};
    mask    = PAT_W'(len_mask(int'(len)));
    fill_ok = (int'(fill) + 1) >= int'(len);
    load_ok = len_ok(int'(pat_len), PAT_W);
    match   = data_vld && !pat_load && fill_ok && (((hist_nx ^ pat) & mask) == '0);
  end

  // Pattern, history and fill tracking; a load cycle swallows any coincident stream bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat     <= DEF_PAT;
      len     <= LEN_W'(DEF_LEN);
      hist    <= '0;
      fill    <= '0;
      match_q <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      match_q <= match;
      if (pat_load) begin
        if (load_ok) begin
          pat  <= pat_val;
          len  <= pat_len;
          fill <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (data_vld) begin
        hist <= hist_nx;
        if (match && !overlap_en) begin
          fill <= '0;
        end else if (int'(fill) < PAT_W) begin
          fill <= fill + LEN_W'(1);
        end
      end
    end
  end

  seq_match_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (cnt_clr),
    .inc  (match),
    .cnt  (match_cnt),
    .sat  (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboard bench for seq_detect_param against a bit-list reference model
module tb_seq_detect_param;

  localparam int PAT_W   = 5;
  localparam int LEN_W   = 3;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rstn;
  logic             data_vld;
  logic             data;
  logic             pat_load;
  logic [PAT_W-1:0] pat_val;
  logic [LEN_W-1:0] pat_len;
  logic             overlap_en;
  logic             cnt_clr;
  logic             match;
  logic             match_q;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic             cfg_err;

  seq_detect_param #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .data_vld   (data_vld),
    .data       (data),
    .pat_load   (pat_load),
    .pat_val    (pat_val),
    .pat_len    (pat_len),
    .overlap_en (overlap_en),
    .cnt_clr    (cnt_clr),
    .match      (match),
    .match_q    (match_q),
    .match_cnt  (match_cnt),
    .cnt_sat    (cnt_sat),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic m;
    int   cnt;
    logic sat;
    logic err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: the list of bits received since the last restart, plus the programmed pattern.
  int               m_bits[$];
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  int               m_cnt;
  logic             m_sat;
  logic             m_err;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_pat = 5'b10010;
    m_len = 5;
    m_cnt = 0;
    m_sat = 1'b0;
    m_err = 1'b0;
  endtask

  // Apply one cycle of stimulus, run the model for it and push the expectation.
  task automatic step(input logic vld, input logic d, input logic ld, input logic [PAT_W-1:0] pv,
                      input logic [LEN_W-1:0] pl, input logic ov, input logic clr);
    exp_t e;
    logic mt;
    @(posedge clk);
    #2;
    data_vld = vld; data = d; pat_load = ld; pat_val = pv; pat_len = pl;
    overlap_en = ov; cnt_clr = clr;
    mt = 1'b0;
    if (ld) begin
      if (pl >= 1 && int'(pl) <= PAT_W) begin
        m_pat = pv;
        m_len = int'(pl);
        m_bits.delete();
      end else begin
        m_err = 1'b1;
      end
    end else if (vld) begin
      m_bits.push_back(int'(d));
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      if (m_bits.size() >= m_len) begin
        mt = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (m_bits[m_bits.size() - 1 - i] != int'(m_pat[i])) mt = 1'b0;
      end
      if (mt && !ov) m_bits.delete();
    end
    if (clr) begin
      m_cnt = 0;
      m_sat = 1'b0;
    end else if (mt) begin
      if (m_cnt == CNT_MAX) m_sat = 1'b1;
      else m_cnt++;
    end
    e.m = mt; e.cnt = m_cnt; e.sat = m_sat; e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, overlap_en, 1'b0);
  endtask

  task automatic feed(input logic [15:0] bits, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, '0, '0, ov, 1'b0);
  endtask

  task automatic load(input logic [PAT_W-1:0] pv, input logic [LEN_W-1:0] pl, input logic vld);
    step(vld, 1'b1, 1'b1, pv, pl, overlap_en, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_match", int'(match), 0);
    check("rst_match_q", int'(match_q), 0);
    check("rst_cnt", int'(match_cnt), 0);
    check("rst_sat", int'(cnt_sat), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
  endtask

  task automatic pulse_reset();
    idle();
    @(posedge clk);
    #3;
    rstn = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    #1;
    rstn = 1'b1;
  endtask

  // Monitor: combinational match checked mid-cycle, registered outputs checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("match", int'(match), int'(e.m));
        @(posedge clk);
        #1;
        check("match_q", int'(match_q), int'(e.m));
        check("match_cnt", int'(match_cnt), e.cnt);
        check("cnt_sat", int'(cnt_sat), int'(e.sat));
        check("cfg_err", int'(cfg_err), int'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int drain;
    rstn = 1'b0; data_vld = 1'b0; data = 1'b0; pat_load = 1'b0; pat_val = '0;
    pat_len = '0; overlap_en = 1'b1; cnt_clr = 1'b0;
    model_reset();
    #14;
    check_reset_outputs();
    #2;
    rstn = 1'b1;

    // Default pattern, overlapping then non-overlapping.
    feed(16'b10010010, 8, 1'b1);
    pulse_reset();
    feed(16'b10010010, 8, 1'b0);

    // Short pattern with idle gaps between bits.
    overlap_en = 1'b1;
    load(5'b00101, 3'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, (i % 2 == 0), 1'b0, '0, '0, 1'b1, 1'b0);
      idle();
      idle();
    end

    // Reset mid-stream discards history and restores the default pattern.
    pulse_reset();
    feed(16'b1001, 4, 1'b1);
    pulse_reset();
    feed(16'b0, 1, 1'b1);
    feed(16'b10010, 5, 1'b1);

    // Counter saturation and clear-wins-over-match.
    load(5'b00010, 3'd2, 1'b0);
    feed(16'b1010101010, 10, 1'b1);
    step(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    feed(16'b10, 2, 1'b1);

    // Illegal lengths leave the pattern alone; a load swallows a coincident bit.
    pulse_reset();
    load(5'b11111, 3'd0, 1'b0);
    load(5'b11111, 3'd6, 1'b0);
    feed(16'b10010, 5, 1'b1);
    feed(16'b1001, 4, 1'b1);
    load(5'b10010, 3'd5, 1'b1);
    feed(16'b0, 1, 1'b1);
    feed(16'b10010, 5, 1'b1);

    // Randomized traffic.
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      logic ld, clr, ov;
      ld  = ($urandom_range(0, 99) < 3);
      clr = ($urandom_range(0, 99) < 4);
      ov  = (i % 50 < 25) ? 1'b1 : logic'($urandom_range(0, 1));
      step(logic'($urandom_range(0, 99) < 75), logic'($urandom_range(0, 1)), ld,
           PAT_W'($urandom), LEN_W'($urandom_range(0, 7)), ov, clr);
    end
    idle();

    drain = 0;
    while (sb.size() > 0 && drain < 100) begin
      @(posedge clk);
      drain++;
    end
    if (sb.size() > 0) check("drain", sb.size(), 0);
    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
